// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause layout, ExcCodes, vector.
// Used by cp0_regfile and cp0_timer (timer only built with CP0_TIMER_EN).
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;

    localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL    = 32'h0000_0001;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic [5:0] ip_hw;
        logic [1:0] ip_sw;
        logic [4:0] exc_code;
    } cause_t;

    function automatic logic [31:0] status_word(status_t s);
        status_word = {16'b0, s.im, 6'b0, s.exl, s.ie};
    endfunction

    // IP[7] carries the timer interrupt on top of hw_int[5]
    function automatic logic [31:0] cause_word(cause_t c, logic tp);
        cause_word = {16'b0, c.ip_hw[5] | tp, c.ip_hw[4:0], c.ip_sw, 1'b0, c.exc_code, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// CP0 pipeline-side bus: mtc0/mfc0 access, commit events, exception redirect.
interface cp0_regfile_if;
    logic        mtc0_wr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        eret;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [5:0]  hw_int;
    logic        exc_flush;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    modport master (
        output mtc0_wr, wr_addr, wr_data, rd_addr, eret, exc_req, exc_code, exc_pc, hw_int,
        input  rd_data, exc_flush, handler_pc, epc_out
    );

    modport slave (
        input  mtc0_wr, wr_addr, wr_data, rd_addr, eret, exc_req, exc_code, exc_pc, hw_int,
        output rd_data, exc_flush, handler_pc, epc_out
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky pending flag; only instantiated under CP0_TIMER_EN.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pend_o
);

    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        pend_q, pend_d;
    logic        wr_count, wr_compare;

    assign wr_count   = wr_en_i && (wr_addr_i == CP0_COUNT);
    assign wr_compare = wr_en_i && (wr_addr_i == CP0_COMPARE);

    // A write to Compare acknowledges the interrupt even on a match cycle
    always_comb begin
        count_d   = wr_count ? wr_data_i : count_q + 32'd1;
        compare_d = wr_compare ? wr_data_i : compare_q;
        pend_d    = wr_compare ? 1'b0 : (pend_q | (count_q == compare_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= COMPARE_RST;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/cp0_regfile.sv
// MIPS-style CP0: Status/Cause/EPC/PRId, exception and eret sequencing, mfc0 bypass.
// Define CP0_TIMER_EN to add Count/Compare and the timer interrupt on IP[7].
module cp0_regfile
    import cp0_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cp0_regfile_if.slave cp0
);

    status_t     status_q, status_d, status_w;
    cause_t      cause_q, cause_d, cause_w;
    logic [31:0] epc_q, epc_d, epc_w;
    logic [31:0] count_w, compare_w;
    logic        timer_pend;
    logic [7:0]  ip;
    logic        int_pending, flush;
    logic        wr_status, wr_cause, wr_epc;

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;

    cp0_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (cp0.mtc0_wr),
        .wr_addr_i (cp0.wr_addr),
        .wr_data_i (cp0.wr_data),
        .count_o   (count),
        .compare_o (compare),
        .pend_o    (timer_pend)
    );

    assign count_w   = (cp0.mtc0_wr && cp0.wr_addr == CP0_COUNT)   ? cp0.wr_data : count;
    assign compare_w = (cp0.mtc0_wr && cp0.wr_addr == CP0_COMPARE) ? cp0.wr_data : compare;
`else
    assign timer_pend = 1'b0;
    assign count_w    = '0;
    assign compare_w  = '0;
`endif

    assign wr_status = cp0.mtc0_wr && (cp0.wr_addr == CP0_STATUS);
    assign wr_cause  = cp0.mtc0_wr && (cp0.wr_addr == CP0_CAUSE);
    assign wr_epc    = cp0.mtc0_wr && (cp0.wr_addr == CP0_EPC);

    // Post-mtc0 views: feed both the read bypass and the next-state logic
    always_comb begin
        status_w = status_q;
        cause_w  = cause_q;
        if (wr_status) begin
            status_w.im  = cp0.wr_data[ST_IM_LO +: 8];
            status_w.exl = cp0.wr_data[ST_EXL];
            status_w.ie  = cp0.wr_data[ST_IE];
        end
        if (wr_cause)
            cause_w.ip_sw = cp0.wr_data[CA_IP_LO +: 2];
    end
    assign epc_w = wr_epc ? cp0.wr_data : epc_q;

    assign ip          = {cause_q.ip_hw[5] | timer_pend, cause_q.ip_hw[4:0], cause_q.ip_sw};
    assign int_pending = status_q.ie & ~status_q.exl & (|(ip & status_q.im));
    assign flush       = rst_n & (cp0.exc_req | int_pending) & ~status_q.exl;

    always_comb begin
        case (cp0.rd_addr)
            CP0_COUNT:   cp0.rd_data = count_w;
            CP0_COMPARE: cp0.rd_data = compare_w;
            CP0_STATUS:  cp0.rd_data = status_word(status_w);
            CP0_CAUSE:   cp0.rd_data = cause_word(cause_w, timer_pend);
            CP0_EPC:     cp0.rd_data = epc_w;
            CP0_PRID:    cp0.rd_data = PRID_VAL;
            default:     cp0.rd_data = '0;
        endcase
    end

    // Exception update is applied last so it overrides mtc0 and eret
    always_comb begin
        status_d       = status_w;
        cause_d        = cause_w;
        cause_d.ip_hw  = cp0.hw_int;
        epc_d          = epc_w;
        if (cp0.eret)
            status_d.exl = 1'b0;
        if (flush) begin
            epc_d            = cp0.exc_pc;
            cause_d.exc_code = cp0.exc_req ? cp0.exc_code : 5'(EXC_INT);
            status_d.exl     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    assign cp0.exc_flush  = flush;
    assign cp0.handler_pc = EXC_VECTOR;
    assign cp0.epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: directed scenarios plus random traffic vs a mask-based model.
module tb_cp0_regfile;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cp0_regfile_if bus ();

    cp0_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cp0   (bus)
    );

    typedef struct packed {
        logic        fl;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    // Architectural model: plain 32-bit words, writes merged through per-register masks
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
    logic        m_tp;

    function automatic logic [31:0] wmask(input logic [4:0] a);
        case (a)
            5'd9, 5'd11: wmask = TIMER ? 32'hFFFF_FFFF : 32'h0;
            5'd12:       wmask = 32'h0000_FF03;
            5'd13:       wmask = 32'h0000_0300;
            5'd14:       wmask = 32'hFFFF_FFFF;
            default:     wmask = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] cur(input logic [4:0] a);
        case (a)
            5'd9:    cur = TIMER ? m_count : 32'h0;
            5'd11:   cur = TIMER ? m_compare : 32'h0;
            5'd12:   cur = m_status;
            5'd13:   cur = m_cause | {16'b0, m_tp, 15'b0};
            5'd14:   cur = m_epc;
            5'd15:   cur = 32'h0000_0001;
            default: cur = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] post(input logic [4:0] a, input logic mw,
                                         input logic [4:0] wa, input logic [31:0] wd);
        if (mw && wa == a) post = (cur(a) & ~wmask(a)) | (wd & wmask(a));
        else               post = cur(a);
    endfunction

    task automatic model_reset();
        m_status  = 32'h0;
        m_cause   = 32'h0;
        m_epc     = 32'h0;
        m_count   = 32'h0;
        m_compare = 32'hFFFF_FFFF;
        m_tp      = 1'b0;
    endtask

    task automatic drv(input logic mw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic er, input logic xr,
                       input logic [4:0] xc, input logic [31:0] xp,
                       input logic [5:0] hw, input logic rn);
        logic [7:0]  ipv;
        logic        pend, fl;
        logic [31:0] n_status, n_cause, pw_cause, n_epc;
        @(posedge clk);
        #1;
        bus.mtc0_wr = mw; bus.wr_addr = wa; bus.wr_data = wd; bus.rd_addr = ra;
        bus.eret = er; bus.exc_req = xr; bus.exc_code = xc; bus.exc_pc = xp;
        bus.hw_int = hw; rst_n = rn;
        if (!rn) model_reset();
        ipv  = cur(5'd13) >> 8;
        pend = m_status[0] & ~m_status[1] & (|(ipv & m_status[15:8]));
        fl   = rn & (xr | pend) & ~m_status[1];
        sbq.push_back('{fl: fl, rd: post(ra, mw, wa, wd), epc: m_epc});
        if (rn) begin
            n_status = post(5'd12, mw, wa, wd);
            pw_cause = post(5'd13, mw, wa, wd);
            n_cause  = {16'b0, hw, pw_cause[9:8], 1'b0, pw_cause[6:2], 2'b0};
            n_epc    = post(5'd14, mw, wa, wd);
            if (er) n_status[1] = 1'b0;
            if (fl) begin
                n_epc        = xp;
                n_cause[6:2] = xr ? xc : 5'd0;
                n_status[1]  = 1'b1;
            end
            if (TIMER) begin
                m_tp      = (mw && wa == 5'd11) ? 1'b0 : (m_tp | (m_count == m_compare));
                m_count   = (mw && wa == 5'd9) ? wd : m_count + 32'd1;
                m_compare = (mw && wa == 5'd11) ? wd : m_compare;
            end
            m_status = n_status;
            m_cause  = n_cause;
            m_epc    = n_epc;
        end
    endtask

    task automatic idle(input logic [4:0] ra, input logic [5:0] hw);
        drv(1'b0, 5'd0, 32'h0, ra, 1'b0, 1'b0, 5'd0, 32'h0, hw, 1'b1);
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
        drv(1'b1, wa, wd, ra, 1'b0, 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every negedge the DUT presents a full response for the current cycle
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("exc_flush", {31'b0, bus.exc_flush}, {31'b0, e.fl});
            chk("rd_data", bus.rd_data, e.rd);
            chk("epc_out", bus.epc_out, e.epc);
            chk("handler_pc", bus.handler_pc, 32'h0000_4180);
        end
    end

    logic [4:0] addrs [6] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    initial begin
        model_reset();
        // Reset with a live exception, eret and mtc0: nothing may stick
        drv(1'b1, 5'd14, 32'hDEAD_BEEF, 5'd12, 1'b1, 1'b1, 5'd8, 32'h1234, 6'h3F, 1'b0);
        drv(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd14, 1'b1, 1'b1, 5'd8, 32'h1234, 6'h3F, 1'b0);
        idle(5'd14, 6'd0);
        idle(5'd15, 6'd0);
        idle(5'd11, 6'd0);

        // Synchronous exception with IE=0
        drv(1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 1'b1, 5'd8, 32'h3010, 6'd0, 1'b1);
        idle(5'd14, 6'd0);
        idle(5'd13, 6'd0);
        idle(5'd12, 6'd0);

        // EXL=1 masks a further exception; eret then clears EXL
        drv(1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 1'b1, 5'd12, 32'h3020, 6'd0, 1'b1);
        idle(5'd14, 6'd0);
        drv(1'b0, 5'd0, 32'h0, 5'd12, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
        idle(5'd12, 6'd0);

        // mtc0 EPC bypass, then register visible on epc_out
        mtc0(5'd14, 32'h3040, 5'd14);
        idle(5'd14, 6'd0);

        // Interrupt on hw_int[0] with IE=1, IM[2]=1
        mtc0(5'd12, 32'h0000_0401, 5'd12);
        drv(1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 1'b0, 5'd0, 32'h5000, 6'b000001, 1'b1);
        drv(1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 1'b0, 5'd0, 32'h5004, 6'b000001, 1'b1);
        idle(5'd14, 6'b000001);
        idle(5'd13, 6'd0);
        idle(5'd12, 6'd0);

        // Exception + eret + mtc0 EPC/Status in one cycle: exception wins
        drv(1'b1, 5'd12, 32'h0, 5'd12, 1'b1, 1'b1, 5'd10, 32'h6000, 6'd0, 1'b1);
        drv(1'b1, 5'd12, 32'h0000_0001, 5'd12, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
        drv(1'b1, 5'd14, 32'h7777, 5'd14, 1'b0, 1'b1, 5'd12, 32'h6100, 6'd0, 1'b1);
        idle(5'd14, 6'd0);
        idle(5'd13, 6'd0);

        // Software interrupt bits and read-only Cause fields through mtc0
        drv(1'b0, 5'd0, 32'h0, 5'd12, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
        mtc0(5'd13, 32'hFFFF_FFFF, 5'd13);
        mtc0(5'd12, 32'h0000_0101, 5'd13);
        idle(5'd14, 6'd0);
        mtc0(5'd3, 32'hFFFF_FFFF, 5'd3);
        mtc0(5'd15, 32'hFFFF_FFFF, 5'd15);
        mtc0(5'd13, 32'h0, 5'd13);
        drv(1'b0, 5'd0, 32'h0, 5'd12, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);

`ifdef CP0_TIMER_EN
        drv(1'b0, 5'd0, 32'h0, 5'd9, 1'b0, 1'b0, 5'd0, 32'h0, 6'd0, 1'b0);
        mtc0(5'd11, 32'd20, 5'd11);
        mtc0(5'd12, 32'h0000_8001, 5'd9);
        for (int i = 0; i < 24; i++) idle(5'd9, 6'd0);
        mtc0(5'd11, 32'd500, 5'd13);
        drv(1'b0, 5'd0, 32'h0, 5'd13, 1'b1, 1'b0, 5'd0, 32'h0, 6'd0, 1'b1);
        idle(5'd13, 6'd0);
        mtc0(5'd9, 32'hFFFF_FFFE, 5'd9);
        for (int i = 0; i < 4; i++) idle(5'd9, 6'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            logic       mw, er, xr, rn;
            logic [4:0] wa, ra;
            int         s;
            s  = $urandom_range(0, 7);
            wa = (s < 6) ? addrs[s] : 5'($urandom);
            s  = $urandom_range(0, 7);
            ra = (s < 6) ? addrs[s] : 5'($urandom);
            mw = ($urandom_range(0, 3) == 0);
            er = ($urandom_range(0, 9) == 0);
            xr = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 99) != 0);
            drv(mw, wa, $urandom, ra, er, xr, 5'($urandom), $urandom,
                ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd0, rn);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port mtc0_wr  input  1  WB-stage mtc0 write enable.
REQ-004 SHALL have port wr_addr  input  5  CP0 register number written by mtc0.
REQ-005 SHALL have port wr_data  input  32  mtc0 write data.
REQ-006 SHALL have port rd_addr  input  5  CP0 register number read by mfc0.
REQ-007 SHALL have port rd_data  output  32  combinational read of rd_addr.
REQ-008 SHALL have port eret  input  1  eret committing this cycle.
REQ-009 SHALL have port exc_req  input  1  synchronous exception (syscall/overflow/illegal) at commit.
REQ-010 SHALL have port exc_code  input  5  ExcCode for exc_req.
REQ-011 SHALL have port exc_pc  input  32  PC of the excepting/interrupted instruction.
REQ-012 SHALL have port hw_int  input  6  external interrupt lines, level-sensitive.
REQ-013 SHALL have port exc_flush  output  1  take exception now: flush pipe, redirect PC.
REQ-014 SHALL have port handler_pc  output  32  constant exception vector 32'h0000_4180.
REQ-015 SHALL have port epc_out  output  32  current EPC register value, for eret redirect.

Function
REQ-016 SHALL implement registers Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15, constant 32'h0000_0001); other numbers read 0, writes ignored.
REQ-017 SHALL use Status fields IE=bit0, EXL=bit1, IM=bits15:8; all other Status bits read 0 and are unwritable.
REQ-018 SHALL use Cause fields ExcCode=bits6:2, IP=bits15:8; Cause is read-only to mtc0 except IP[1:0] (software interrupts).
REQ-019 SHALL sample Cause.IP[7:2] from hw_int every cycle (IP[7] ORed with timer pending when enabled).
REQ-020 SHALL compute int_pending = IE & ~EXL & |(IP & IM) from registered values.
REQ-021 SHALL assert exc_flush combinationally when (exc_req | int_pending) & ~EXL; never while EXL=1.
REQ-022 SHALL, on the edge following exc_flush: EPC<=exc_pc, Cause.ExcCode<=(exc_req ? exc_code : 0), EXL<=1.
REQ-023 SHALL give exc_req priority over int_pending when both are true in one cycle.
REQ-024 SHALL clear EXL on the edge following eret when exc_flush is low; exc_flush+eret same cycle: exception wins, EXL stays 1.
REQ-025 SHALL apply mtc0 writes on the next edge; exception update overrides an mtc0 to the same field in the same cycle.
REQ-026 SHALL bypass rd_data: mtc0_wr & wr_addr==rd_addr returns the post-write value of the target register (wr_data masked to its writable fields; read-only fields keep their current value) in that cycle.
REQ-027 SHALL drive epc_out from the EPC register (no internal bypass; upstream forwarding covers in-flight mtc0).

Reset
REQ-028 SHALL, while rst_n=0, hold Status=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF, timer pending=0; exc_flush=0.
REQ-029 SHALL abandon any same-cycle exception/eret/mtc0 when rst_n falls; no partial update survives.

Configuration
REQ-030 SHALL, with CP0_TIMER_EN defined, increment Count every cycle (wrap 32'hFFFF_FFFF->0), set timer pending when Count==Compare, clear it on any mtc0 to Compare, and OR it into IP[7].
REQ-031 SHALL, without CP0_TIMER_EN, read Count/Compare as 0, ignore writes, and leave IP[7]=hw_int[5].

Structure
REQ-032 SHALL place register numbers, Status/Cause bit positions, ExcCode values and the exception vector in shared package cp0_pkg.
REQ-033 SHALL isolate Count/Compare/timer-pending logic in sub-module cp0_timer, instantiated only under CP0_TIMER_EN.

Verification
REQ-034 SHALL check: mtc0 Status=32'h0000_0401 then hw_int=6'b000001 -> exc_flush=1 next cycle, EPC=exc_pc, ExcCode=0, EXL=1.
REQ-035 SHALL check: exc_req=1, exc_code=8, exc_pc=32'h3010 with IE=0 -> exc_flush=1, EPC=32'h3010, Cause[6:2]=8.
REQ-036 SHALL check: EXL=1, exc_req=1 -> exc_flush=0, EPC unchanged; then eret -> EXL=0 next edge.
REQ-037 SHALL check: mtc0 EPC=32'h3040 with rd_addr=14 same cycle -> rd_data=32'h3040 that cycle, epc_out=32'h3040 next cycle.
REQ-038 SHALL check (CP0_TIMER_EN): Compare=20, Status=32'h0000_8001 -> exc_flush when Count reaches 20; mtc0 Compare clears pending.
